// File: rtl/smi_pkg.sv
// smi_pkg: shared types and constants for the SMI host initiator.
// FSM encoding, direction codes, write-frame marker masks and unit lengths.
package smi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } smi_state_e;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  // Write frame markers: byte0 (I low) carries bit0=1, byte2 (Q low) bit0=0.
  localparam logic [7:0] TX_B0_MARK_SET = 8'h01;
  localparam logic [7:0] TX_B2_MARK_CLR = 8'hFE;

  localparam int unsigned RX_BYTES = 2;
  localparam int unsigned TX_BYTES = 4;

  localparam logic [1:0] RX_LAST_IDX = 2'(RX_BYTES - 1);
  localparam logic [1:0] TX_LAST_IDX = 2'(TX_BYTES - 1);

  // Bus byte for position idx of a write unit, with frame markers applied.
  function automatic logic [7:0] tx_byte(input logic [31:0] pair, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = pair[7:0] | TX_B0_MARK_SET;
      2'd1:    b = pair[15:8];
      2'd2:    b = pair[23:16] & TX_B2_MARK_CLR;
      default: b = pair[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/smi_host_ctrl_timer.sv
// smi_phase_timer: 4-bit down-counter shared by the SETUP/STROBE/HOLD phases.
// Loading N-1 on phase entry makes done_o assert on the phase's Nth cycle.
module smi_phase_timer (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/smi_host_ctrl.sv
// smi_host_ctrl: SMI bus initiator (host end of the byte-wide SMI link).
// Reads collect byte pairs into 16-bit words; writes serialise a 32-bit I/Q
// pair into four marker-framed bytes. Optional statistics outputs are built
// when the macro SMI_HOST_STATS_EN is defined.
module smi_host_ctrl
  import smi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_b,
  input  logic        i_rx_en,
  input  logic        i_tx_en,
  input  logic        i_tx_valid,
  input  logic [31:0] i_tx_data,
  output logic        o_tx_ready,
  output logic        o_rx_valid,
  output logic [15:0] o_rx_data,
  input  logic        i_rx_ready,
  output logic        o_smi_soe_se,
  output logic        o_smi_swe_srw,
  output logic [7:0]  o_smi_data_out,
  output logic        o_smi_data_oe,
  input  logic [7:0]  i_smi_data_in,
  input  logic        i_smi_read_req,
  input  logic        i_smi_write_req,
  output logic        o_busy
`ifdef SMI_HOST_STATS_EN
  ,
  output logic [15:0] o_tx_pair_cnt,
  output logic [15:0] o_rx_word_cnt,
  output logic        o_rx_stall
`endif
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  smi_state_e  state_q;
  logic        dir_q;
  logic        last_q;
  logic [1:0]  idx_q;
  logic [31:0] pair_q;
  logic        soe_q, swe_q, oe_q, tx_ready_q, rx_valid_q;
  logic [7:0]  dout_q;
  logic [15:0] rx_data_q;

  logic       rx_elig, tx_elig, start, start_dir;
  logic [1:0] last_idx;
  logic       tmr_load, tmr_done, unit_done;
  logic [3:0] tmr_val;

  // Eligibility, arbitration and phase-timer reload decisions.
  always_comb begin
    rx_elig   = i_rx_en & i_smi_read_req & (!rx_valid_q | i_rx_ready);
    tx_elig   = i_tx_en & i_tx_valid & i_smi_write_req;
    start     = (state_q == ST_IDLE) & (rx_elig | tx_elig);
    start_dir = (rx_elig & tx_elig) ? ~last_q : tx_elig;
    last_idx  = (dir_q == DIR_TX) ? TX_LAST_IDX : RX_LAST_IDX;
    unit_done = (state_q == ST_HOLD) & tmr_done & (idx_q == last_idx);
    tmr_load  = 1'b0;
    tmr_val   = 4'd0;
    case (state_q)
      ST_IDLE:   if (start)    begin tmr_load = 1'b1; tmr_val = SETUP_LD;  end
      ST_SETUP:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = STROBE_LD; end
      ST_STROBE: if (tmr_done) begin tmr_load = 1'b1; tmr_val = HOLD_LD;   end
      ST_HOLD:   if (tmr_done && idx_q != last_idx) begin
        tmr_load = 1'b1;
        tmr_val  = SETUP_LD;
      end
      default: ;
    endcase
  end

  smi_phase_timer u_timer (
    .i_sys_clk  (i_sys_clk),
    .i_rst_b    (i_rst_b),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Transfer FSM with registered bus strobes, data and handshake outputs.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_RX;
      last_q     <= DIR_RX;
      idx_q      <= 2'd0;
      pair_q     <= 32'd0;
      soe_q      <= 1'b1;
      swe_q      <= 1'b1;
      oe_q       <= 1'b0;
      dout_q     <= 8'd0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 16'd0;
    end else begin
      tx_ready_q <= 1'b0;
      if (rx_valid_q && i_rx_ready) rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SETUP;
            dir_q   <= start_dir;
            last_q  <= start_dir;
            idx_q   <= 2'd0;
            if (start_dir == DIR_TX) begin
              tx_ready_q <= 1'b1;
              pair_q     <= i_tx_data;
              dout_q     <= tx_byte(i_tx_data, 2'd0);
              oe_q       <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state_q <= ST_STROBE;
            if (dir_q == DIR_RX) soe_q <= 1'b0;
            else                 swe_q <= 1'b0;
          end
        end
        ST_STROBE: begin
          if (tmr_done) begin
            state_q <= ST_HOLD;
            soe_q   <= 1'b1;
            swe_q   <= 1'b1;
            if (dir_q == DIR_RX) begin
              if (idx_q == 2'd0) begin
                rx_data_q[7:0] <= i_smi_data_in;
              end else begin
                rx_data_q[15:8] <= i_smi_data_in;
                rx_valid_q      <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (tmr_done) begin
            if (idx_q == last_idx) begin
              state_q <= ST_IDLE;
              oe_q    <= 1'b0;
            end else begin
              state_q <= ST_SETUP;
              idx_q   <= idx_q + 2'd1;
              if (dir_q == DIR_TX) dout_q <= tx_byte(pair_q, idx_q + 2'd1);
            end
          end
        end
      endcase
    end
  end

  assign o_tx_ready     = tx_ready_q;
  assign o_rx_valid     = rx_valid_q;
  assign o_rx_data      = rx_data_q;
  assign o_smi_soe_se   = soe_q;
  assign o_smi_swe_srw  = swe_q;
  assign o_smi_data_out = dout_q;
  assign o_smi_data_oe  = oe_q;
  assign o_busy         = (state_q != ST_IDLE);

`ifdef SMI_HOST_STATS_EN
  logic [15:0] tx_cnt_q, rx_cnt_q;
  logic        stall_q;

  // Saturating unit counters and sticky read-backpressure flag.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      tx_cnt_q <= 16'd0;
      rx_cnt_q <= 16'd0;
      stall_q  <= 1'b0;
    end else begin
      if (unit_done && dir_q == DIR_TX && tx_cnt_q != 16'hFFFF) tx_cnt_q <= tx_cnt_q + 16'd1;
      if (unit_done && dir_q == DIR_RX && rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;
      if (i_smi_read_req && i_rx_en && rx_valid_q && !i_rx_ready) stall_q <= 1'b1;
    end
  end

  assign o_tx_pair_cnt = tx_cnt_q;
  assign o_rx_word_cnt = rx_cnt_q;
  assign o_rx_stall    = stall_q;
`endif

endmodule

// File: tb/tb_smi_host_ctrl.sv
// tb_smi_host_ctrl: directed/randomized bench for smi_host_ctrl with a
// byte-level peripheral model, bus monitor and reference framing model.
module tb_smi_host_ctrl;

  localparam int STROBE = 3;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        i_rx_en, i_tx_en, i_tx_valid, i_rx_ready;
  logic [31:0] i_tx_data;
  logic        o_tx_ready, o_rx_valid;
  logic [15:0] o_rx_data;
  logic        o_smi_soe_se, o_smi_swe_srw, o_smi_data_oe;
  logic [7:0]  o_smi_data_out, i_smi_data_in;
  logic        i_smi_read_req, i_smi_write_req, o_busy;
`ifdef SMI_HOST_STATS_EN
  logic [15:0] o_tx_pair_cnt, o_rx_word_cnt;
  logic        o_rx_stall;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0]  src [512];
  int          rd_ptr = 0;
  logic [31:0] tx_todo [$];
  logic [31:0] tx_sent [$];
  logic [7:0]  wr_bytes [$];
  logic [15:0] rx_got [$];
  int          soe_w [$];
  int          swe_w [$];
  int          busy_w [$];
  bit          units [$];
  int          oe_bad = 0, oe_cycles = 0, soe_low_total = 0, tx_ready_cnt = 0;

  smi_host_ctrl dut (
    .i_sys_clk       (clk),
    .i_rst_b         (rst_b),
    .i_rx_en         (i_rx_en),
    .i_tx_en         (i_tx_en),
    .i_tx_valid      (i_tx_valid),
    .i_tx_data       (i_tx_data),
    .o_tx_ready      (o_tx_ready),
    .o_rx_valid      (o_rx_valid),
    .o_rx_data       (o_rx_data),
    .i_rx_ready      (i_rx_ready),
    .o_smi_soe_se    (o_smi_soe_se),
    .o_smi_swe_srw   (o_smi_swe_srw),
    .o_smi_data_out  (o_smi_data_out),
    .o_smi_data_oe   (o_smi_data_oe),
    .i_smi_data_in   (i_smi_data_in),
    .i_smi_read_req  (i_smi_read_req),
    .i_smi_write_req (i_smi_write_req),
    .o_busy          (o_busy)
`ifdef SMI_HOST_STATS_EN
    ,
    .o_tx_pair_cnt   (o_tx_pair_cnt),
    .o_rx_word_cnt   (o_rx_word_cnt),
    .o_rx_stall      (o_rx_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference framing: I word gets bit0=1, Q word bit0=0, sent low byte first.
  function automatic logic [7:0] exp_tx_byte(input logic [31:0] pair, input int k);
    logic [15:0] iw, qw;
    iw = pair[15:0] | 16'h0001;
    qw = pair[31:16] & 16'hFFFE;
    case (k)
      0:       return iw[7:0];
      1:       return iw[15:8];
      2:       return qw[7:0];
      default: return qw[15:8];
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input int k);
    return {src[2*k+1], src[2*k]};
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 300) begin @(posedge clk); #1; n++; end
    chk(tag, 32'(o_busy), 32'd0);
  endtask

  // Peripheral read side: data is only valid for the last strobe cycle.
  initial begin
    i_smi_data_in = 8'h00;
    forever begin
      @(negedge o_smi_soe_se);
      i_smi_data_in = 8'($urandom);
      repeat (STROBE - 1) @(posedge clk);
      #1 i_smi_data_in = src[rd_ptr];
      rd_ptr++;
      @(posedge o_smi_soe_se);
      i_smi_data_in = 8'($urandom);
    end
  end

  // Upstream I/Q source: presents the head of tx_todo, pops it on acceptance.
  initial begin
    i_tx_valid = 1'b0;
    i_tx_data  = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (o_tx_ready && tx_todo.size() != 0) tx_sent.push_back(tx_todo.pop_front());
      i_tx_valid = (tx_todo.size() != 0);
      i_tx_data  = i_tx_valid ? tx_todo[0] : 32'h0;
    end
  end

  // Bus monitor: strobe widths, written bytes, unit directions, received words.
  initial begin
    bit prev_soe = 1, prev_swe = 1, prev_busy = 0, pend = 0;
    int soe_run = 0, swe_run = 0, busy_run = 0;
    forever begin
      @(negedge clk);
      if (!o_smi_swe_srw && prev_swe) wr_bytes.push_back(o_smi_data_out);
      if (!o_smi_soe_se) soe_run++;
      else if (soe_run != 0) begin soe_w.push_back(soe_run); soe_run = 0; end
      if (!o_smi_swe_srw) swe_run++;
      else if (swe_run != 0) begin swe_w.push_back(swe_run); swe_run = 0; end
      if (o_busy) busy_run++;
      else if (busy_run != 0) begin busy_w.push_back(busy_run); busy_run = 0; end
      if (o_busy && !prev_busy) pend = 1;
      if (pend && !o_smi_soe_se) begin units.push_back(1'b0); pend = 0; end
      else if (pend && !o_smi_swe_srw) begin units.push_back(1'b1); pend = 0; end
      if ((!o_smi_swe_srw && !o_smi_data_oe) || (!o_smi_soe_se && o_smi_data_oe)) oe_bad++;
      if (o_smi_data_oe) oe_cycles++;
      if (!o_smi_soe_se) soe_low_total++;
      if (o_rx_valid && i_rx_ready) rx_got.push_back(o_rx_data);
      if (o_tx_ready) tx_ready_cnt++;
      prev_soe = o_smi_soe_se; prev_swe = o_smi_swe_srw; prev_busy = o_busy;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wb, sb, tr, ub, oec, widx, bad, slo;
    logic [31:0] p;

    for (int i = 0; i < 512; i++) src[i] = 8'($urandom);
    src[0] = 8'h34;
    src[1] = 8'h12;
    rst_b = 1'b0;
    i_rx_en = 0; i_tx_en = 0; i_rx_ready = 1; i_smi_read_req = 0; i_smi_write_req = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_soe", 32'(o_smi_soe_se), 32'd1);
    chk("rst_swe", 32'(o_smi_swe_srw), 32'd1);
    chk("rst_oe", 32'(o_smi_data_oe), 32'd0);
    chk("rst_dout", 32'(o_smi_data_out), 32'd0);
    chk("rst_rxv", 32'(o_rx_valid), 32'd0);
    chk("rst_rxd", 32'(o_rx_data), 32'd0);
    chk("rst_txr", 32'(o_tx_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1 rst_b = 1'b1;

    // Reads with default timing
    i_rx_en = 1; i_smi_read_req = 1; i_rx_ready = 1;
    n = 0;
    while (rx_got.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    chk("rd_wait", 32'(rx_got.size() >= 2), 32'd1);
    i_rx_en = 0;
    wait_idle("rd_idle");
    chk("rd_word0", 32'(rx_got[0]), 32'h1234);
    chk("rd_word1", 32'(rx_got[1]), 32'(exp_word(1)));
    bad = 0;
    for (int i = 0; i < 4; i++) if (soe_w[i] != STROBE) bad++;
    chk("rd_soe_width", 32'(bad), 32'd0);
    chk("rd_unit_cycles", 32'(busy_w[0]), 32'd14);

    // Write framing
    wb = wr_bytes.size(); sb = tx_sent.size(); tr = tx_ready_cnt; oec = oe_cycles;
    tx_todo.push_back(32'hBEEF1234);
    tx_todo.push_back($urandom);
    tx_todo.push_back($urandom);
    i_tx_en = 1; i_smi_write_req = 1;
    n = 0;
    while (tx_sent.size() < sb + 3 && n < 200) begin @(posedge clk); #1; n++; end
    chk("wr_wait", 32'(tx_sent.size()), 32'(sb + 3));
    wait_idle("wr_idle");
    i_tx_en = 0;
    chk("wr_b0", 32'(wr_bytes[wb]), 32'h35);
    chk("wr_b1", 32'(wr_bytes[wb+1]), 32'h12);
    chk("wr_b2", 32'(wr_bytes[wb+2]), 32'hEE);
    chk("wr_b3", 32'(wr_bytes[wb+3]), 32'hBE);
    chk("wr_nbytes", 32'(wr_bytes.size() - wb), 32'd12);
    bad = 0;
    for (int u = 0; u < 3; u++)
      for (int k = 0; k < 4; k++)
        if (wr_bytes[wb+4*u+k] !== exp_tx_byte(tx_sent[sb+u], k)) bad++;
    chk("wr_frames", 32'(bad), 32'd0);
    bad = 0;
    foreach (swe_w[i]) if (swe_w[i] != STROBE) bad++;
    chk("wr_swe_width", 32'(bad), 32'd0);
    chk("wr_oe_cycles", 32'(oe_cycles - oec), 32'd84);
    chk("wr_oe_bad", 32'(oe_bad), 32'd0);
    chk("wr_ready_pulses", 32'(tx_ready_cnt - tr), 32'd3);

    // Read backpressure
    widx = rx_got.size();
    i_rx_ready = 0; i_rx_en = 1;
    n = 0;
    while (!o_rx_valid && n < 60) begin @(posedge clk); #1; n++; end
    chk("bp_valid", 32'(o_rx_valid), 32'd1);
    wait_idle("bp_idle");
    slo = soe_low_total;
    repeat (30) @(posedge clk);
    #1;
    chk("bp_no_soe", 32'(soe_low_total - slo), 32'd0);
    chk("bp_hold_valid", 32'(o_rx_valid), 32'd1);
    chk("bp_hold_data", 32'(o_rx_data), 32'(exp_word(widx)));
`ifdef SMI_HOST_STATS_EN
    chk("st_stall_set", 32'(o_rx_stall), 32'd1);
`endif
    i_rx_ready = 1;
    n = 0;
    while (rx_got.size() < widx + 2 && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_resume", 32'(rx_got.size() >= widx + 2), 32'd1);
    i_rx_en = 0;
    wait_idle("bp_idle2");
    chk("bp_word_a", 32'(rx_got[widx]), 32'(exp_word(widx)));
    chk("bp_word_b", 32'(rx_got[widx+1]), 32'(exp_word(widx + 1)));

    // Arbitration right after reset: both eligible -> TX first, then alternate
    @(posedge clk); #1 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    for (int i = 0; i < 4; i++) tx_todo.push_back($urandom);
    repeat (2) @(posedge clk);
    #1;
    ub = units.size();
    i_rx_en = 1; i_tx_en = 1; i_smi_read_req = 1; i_smi_write_req = 1; i_rx_ready = 1;
    n = 0;
    while (units.size() < ub + 4 && n < 300) begin @(posedge clk); #1; n++; end
    chk("arb_wait", 32'(units.size() >= ub + 4), 32'd1);
    i_rx_en = 0; i_tx_en = 0;
    wait_idle("arb_idle");
    tx_todo.delete();
    for (int i = 0; i < 4; i++) chk($sformatf("arb_unit%0d", i), 32'(units[ub+i]), 32'((i % 2) == 0));
    repeat (2) @(posedge clk);
    #1;

    // Mid-unit disable: unit completes, no new unit starts
    wb = wr_bytes.size(); sb = tx_sent.size(); tr = tx_ready_cnt;
    tx_todo.push_back($urandom);
    tx_todo.push_back($urandom);
    repeat (2) @(posedge clk);
    #1 i_tx_en = 1;
    n = 0;
    while (wr_bytes.size() < wb + 1 && n < 60) begin @(posedge clk); #1; n++; end
    i_tx_en = 0;
    wait_idle("dis_idle");
    repeat (40) @(posedge clk);
    #1;
    chk("dis_nbytes", 32'(wr_bytes.size() - wb), 32'd4);
    chk("dis_ready_pulses", 32'(tx_ready_cnt - tr), 32'd1);
    bad = 0;
    for (int k = 0; k < 4; k++) if (wr_bytes[wb+k] !== exp_tx_byte(tx_sent[sb], k)) bad++;
    chk("dis_frame", 32'(bad), 32'd0);
    tx_todo.delete();
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset during strobe of write byte 2
    wb = wr_bytes.size();
    tx_todo.push_back($urandom);
    i_tx_en = 1;
    n = 0;
    while (wr_bytes.size() < wb + 3 && n < 80) begin @(posedge clk); #1; n++; end
    chk("ar_reach", 32'(o_smi_swe_srw), 32'd0);
    #2 rst_b = 1'b0;
    #1;
    chk("ar_swe", 32'(o_smi_swe_srw), 32'd1);
    chk("ar_oe", 32'(o_smi_data_oe), 32'd0);
    chk("ar_soe", 32'(o_smi_soe_se), 32'd1);
    chk("ar_busy", 32'(o_busy), 32'd0);
    i_tx_en = 0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
`ifdef SMI_HOST_STATS_EN
    chk("st_txcnt0", 32'(o_tx_pair_cnt), 32'd0);
    chk("st_rxcnt0", 32'(o_rx_word_cnt), 32'd0);
    chk("st_stall0", 32'(o_rx_stall), 32'd0);
`endif
    wb = wr_bytes.size(); sb = tx_sent.size();
    p = ($urandom & 32'hFFFF_FFFE) | 32'h0001_0000;
    tx_todo.push_back(p);
    repeat (2) @(posedge clk);
    #1 i_tx_en = 1;
    n = 0;
    while (wr_bytes.size() < wb + 4 && n < 80) begin @(posedge clk); #1; n++; end
    i_tx_en = 0;
    wait_idle("ar_idle");
    chk("ar_b0_marker", 32'(wr_bytes[wb][0]), 32'd1);
    bad = 0;
    for (int k = 0; k < 4; k++) if (wr_bytes[wb+k] !== exp_tx_byte(p, k)) bad++;
    chk("ar_frame", 32'(bad), 32'd0);
`ifdef SMI_HOST_STATS_EN
    chk("st_txcnt1", 32'(o_tx_pair_cnt), 32'd1);
`endif

    // All received words against the peripheral byte stream
    bad = 0;
    foreach (rx_got[i]) if (rx_got[i] !== exp_word(i)) bad++;
    chk("rx_stream", 32'(bad), 32'd0);
    chk("oe_rule", 32'(oe_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
